// File: rtl/tbuf_drive_ctrl.sv
// tbuf_drive_ctrl: sequential driver controller for a bank of TBUF cells on a
// shared tristate bus. It takes words over a valid/ready handshake, requests
// the bus from an external arbiter and drives bursts only while granted. Every
// burst is followed by a fixed number of released (high-Z) turnaround cycles,
// so two drivers never contend.
//
// Ports:
//   CLK     in   sole clock, rising edge
//   RST     in   asynchronous, active-high reset
//   DIN     in   [WIDTH] word to drive
//   DVALID  in   DIN valid
//   DREADY  out  controller can take DIN (combinational on GNT while driving)
//   REQ     out  bus request to the arbiter (registered)
//   GNT     in   bus grant from the arbiter
//   TBI     out  [WIDTH] TBUF I inputs (registered)
//   TBT     out  [WIDTH] TBUF T inputs, active-low enable (registered; all ones = released)
//   BUSY    out  high whenever the controller is not idle
module tbuf_drive_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAXBURST = 4,
  parameter int unsigned TURN     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             REQ,
  input  logic             GNT,
  output logic [WIDTH-1:0] TBI,
  output logic [WIDTH-1:0] TBT,
  output logic             BUSY
);

  localparam int unsigned BCNT_W = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam int unsigned TCNT_W = (TURN > 1) ? $clog2(TURN) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAXBURST - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TURN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    hold_q,  hold_d;
  logic [BCNT_W-1:0]   bcnt_q,  bcnt_d;
  logic [TCNT_W-1:0]   tcnt_q,  tcnt_d;
  logic [WIDTH-1:0]    tbi_q,   tbi_d;
  logic [WIDTH-1:0]    tbt_q,   tbt_d;
  logic                req_q,   req_d;
  logic                dready_c;

  // State and datapath registers; reset takes effect without a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      tbi_q   <= '0;
      tbt_q   <= '1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      tbi_q   <= tbi_d;
      tbt_q   <= tbt_d;
      req_q   <= req_d;
    end
  end

  // Next-state and output decode.
  // TBT defaults to released every cycle and is pulled low only on the two
  // paths that keep or enter DRIVE with the bus granted, so no other path can
  // leave the buffers enabled.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    tbi_d    = tbi_q;
    tbt_d    = '1;
    req_d    = req_q;
    dready_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dready_c = 1'b1;
        if (DVALID) begin
          hold_d  = DIN;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (GNT) begin
          tbi_d   = hold_q;
          tbt_d   = '0;
          bcnt_d  = '0;
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: begin
        // The last word of a burst never accepts a successor, which also keeps
        // BCNT saturated at MAXBURST-1.
        dready_c = GNT && (bcnt_q < BCNT_LAST);
        if (DVALID && dready_c) begin
          tbi_d  = DIN;
          tbt_d  = '0;
          bcnt_d = bcnt_q + BCNT_W'(1);
        end else begin
          tbi_d   = '0;
          req_d   = 1'b0;
          tcnt_d  = '0;
          state_d = S_TURN;
        end
      end

      S_TURN: begin
        if (tcnt_q == TCNT_LAST) begin
          tcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign DREADY = dready_c & ~RST;
  assign REQ    = req_q;
  assign TBI    = tbi_q;
  assign TBT    = tbt_q;
  assign BUSY   = (state_q != S_IDLE);

endmodule
